i2c_byte_engine: RTL
====================

// Module: i2c_byte_engine
// PURPOSE
//  Byte-level I2C master engine for the TMP101 lab controller: on Go, optionally emits START,
//  transfers one byte (write or read) MSB-first plus ACK slot, optionally emits STOP.
//  Generates SCL/SDA timing and drives the 8-bit I2C shift register's load/shift controls.
//  Sits between the transaction FSM (issues byte commands) and the open-drain pad buffers.
// PARAMETERS
//  QUARTER_DIV  250  CLOCK cycles per quarter SCL bit-period (4 quarters per bit); must be >=2
// PORTS
//  CLOCK       in   1  system clock
//  Reset       in   1  synchronous, active-high reset
//  Go          in   1  command strobe; sampled only while Busy=0
//  SendStart   in   1  with Go: emit START (or repeated START) before data
//  SendStop    in   1  with Go: emit STOP after ACK slot
//  ReadNotWrite in  1  with Go: 1=read byte from slave, 0=write TxByte
//  AckOut      in   1  with Go (read): 1=master drives ACK, 0=NACK
//  TxByte      in   8  byte to write, captured on accepted Go
//  SDA_in      in   1  synchronised SDA pad level
//  SCL         out  1  SCL level (1=released/high)
//  SDA_oe      out  1  1=pull SDA low, 0=release
//  RxByte      out  8  received byte (shift register contents), valid with Done
//  AckIn       out  1  write: 1=slave ACKed (SDA low in ACK slot); read: 0
//  Busy        out  1  command in progress
//  Done        out  1  one-cycle completion pulse
// BEHAVIOUR
//  Reset: SCL=1, SDA_oe=0, Busy=0, Done=0, AckIn=0, RxByte=0, state=IDLE, counters=0.
//  Go accepted only when Busy=0 in IDLE; Go while Busy ignored, inputs not re-captured.
//  Accept cycle t: capture flags; write -> WriteLoad=1 loads TxByte; Busy=1 from t+1.
//  Bit slot = 4 quarters Q0..Q3, each QUARTER_DIV cycles, quarter counter 0..QUARTER_DIV-1.
//  States: IDLE -> [START] -> DATA(x8) -> ACK -> [STOP] -> DONE -> IDLE.
//   START: Q0 SCL=0,SDA rel; Q1 SCL=1,SDA rel; Q2 SCL=1,SDA low; Q3 SCL=0,SDA low.
//     (from idle bus the Q0 SCL-low is harmless; same sequence gives repeated START)
//   DATA: SCL=0,1,1,0 over Q0..Q3; write: SDA_oe=~ShiftOut all 4 quarters; read: SDA_oe=0.
//     SDA_in captured into sample flop on first cycle of Q2; ShiftorHold=1 for one cycle
//     on last cycle of Q3 with ShiftIn=sample flop. Bit counter 7..0, DATA->ACK after bit 0.
//   ACK: SCL as DATA; write: SDA_oe=0, AckIn<=~SDA_in at Q2 first cycle;
//     read: SDA_oe=AckOut all quarters. No shift in ACK.
//   STOP: Q0 SCL=0,SDA low; Q1 SCL=1,SDA low; Q2,Q3 SCL=1,SDA rel.
//   DONE: one cycle, Done=1, Busy=0 same cycle; SCL/SDA hold last values.
//  Without STOP: SCL stays 0 after ACK (bus held) until next Go; SDA_oe=0 in idle-held.
//  Latency: Done at t+1+4*QUARTER_DIV*N, N=9+SendStart+SendStop slots.
//  After write byte, RxByte = byte read back from SDA (equals TxByte if no contention).
//  No clock stretching, no arbitration detection; SDA/SCL changes only while SCL=0
//  except START/STOP edges.
//  Reset mid-operation: immediate return to reset values (bus released; may look like STOP).
// STRUCTURE
//  Shared package i2c_pkg: state encodings, quarter encodings Q0..Q3, I2C_BYTE_LEN=8.
//  Sub-module: I2C_ShiftRegister (LENGTH=8): WriteLoad, ShiftorHold, ShiftIn, SentData,
//  ShiftOut, ReceivedData; engine owns quarter counter, bit counter, FSM, sample flop.
// TESTING  (QUARTER_DIV=4, slot=16 cycles; I2C slave BFM)
//  Go,Start,Stop,write 0xA5, slave ACKs -> SDA at SCL rise 1,0,1,0,0,1,0,1; AckIn=1; Done at t+177.
//  Go,Start,Stop,read, AckOut=0, slave sends 0x3C -> RxByte=0x3C, SDA released in ACK slot, Done t+177.
//  Write 0x90 no slave -> AckIn=0; START then STOP edges seen with SCL high.
//  Start,no-Stop write then Start,Stop read -> SCL held 0 between, repeated START, Done t+161 then t+177.
//  Go pulsed while Busy with different TxByte -> ignored, original byte sent, one Done only.
//  Reset asserted mid-DATA bit 4 -> next cycle SCL=1,SDA_oe=0,Busy=0,RxByte=0; new Go works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C byte engine: FSM states, SCL quarter phases
// and the byte length used by the shift register.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  // SCL is high only in the middle two quarters of a START/DATA/ACK slot.
  function automatic logic slot_scl(input quarter_t q);
    return (q == Q1) || (q == Q2);
  endfunction

endpackage

// File: rtl/i2c_byte_engine_shiftreg.sv
// MSB-first parallel-load shift register shared by the transmit and receive
// paths of the I2C byte engine.
module I2C_ShiftRegister
  import i2c_pkg::*;
#(
  parameter int unsigned LENGTH = I2C_BYTE_LEN
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              WriteLoad,
  input  logic              ShiftorHold,
  input  logic              ShiftIn,
  input  logic [LENGTH-1:0] SentData,
  output logic              ShiftOut,
  output logic [LENGTH-1:0] ReceivedData
);

  logic [LENGTH-1:0] data_q;

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      data_q <= '0;
    end else if (WriteLoad) begin
      data_q <= SentData;
    end else if (ShiftorHold) begin
      data_q <= {data_q[LENGTH-2:0], ShiftIn};
    end
  end

  assign ShiftOut     = data_q[LENGTH-1];
  assign ReceivedData = data_q;

endmodule

// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master: optional START, one byte MSB-first plus ACK slot,
// optional STOP, with SCL/SDA generated from a quarter-bit timebase.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_DIV = 250
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       Go,
  input  logic       SendStart,
  input  logic       SendStop,
  input  logic       ReadNotWrite,
  input  logic       AckOut,
  input  logic [7:0] TxByte,
  input  logic       SDA_in,
  output logic       SCL,
  output logic       SDA_oe,
  output logic [7:0] RxByte,
  output logic       AckIn,
  output logic       Busy,
  output logic       Done
);

  localparam int unsigned QW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
  localparam int unsigned BW = $clog2(I2C_BYTE_LEN);
  localparam logic [QW-1:0] QLAST = QW'(QUARTER_DIV - 1);
  localparam int unsigned MSB = I2C_BYTE_LEN - 1;

  state_t   state_q,   state_d;
  quarter_t quarter_q, quarter_d;
  logic [QW-1:0] qcnt_q,   qcnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic rnw_q,    rnw_d;
  logic stop_q,   stop_d;
  logic ackout_q, ackout_d;
  logic scl_q,    scl_d;
  logic sda_oe_q, sda_oe_d;
  logic sample_q, ackin_q, busy_q, done_q;

  logic accept, quarter_end, slot_end, q2_first;
  logic write_load, shift_en, shift_out, tx_bit_d;
  logic [I2C_BYTE_LEN-1:0] sr_data;

  always_comb begin
    accept      = (state_q == ST_IDLE) && Go;
    quarter_end = (qcnt_q == QLAST);
    slot_end    = quarter_end && (quarter_q == Q3);
    q2_first    = (quarter_q == Q2) && (qcnt_q == '0);
    write_load  = accept && !ReadNotWrite;
    shift_en    = (state_q == ST_DATA) && slot_end;
  end

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    qcnt_d    = qcnt_q;
    bitcnt_d  = bitcnt_q;
    rnw_d     = rnw_q;
    stop_d    = stop_q;
    ackout_d  = ackout_q;
    case (state_q)
      ST_IDLE: begin
        if (Go) begin
          state_d   = SendStart ? ST_START : ST_DATA;
          quarter_d = Q0;
          qcnt_d    = '0;
          bitcnt_d  = BW'(MSB);
          rnw_d     = ReadNotWrite;
          stop_d    = SendStop;
          ackout_d  = AckOut;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (quarter_end) begin
          qcnt_d    = '0;
          quarter_d = quarter_t'(quarter_q + 2'd1);
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
        if (slot_end) begin
          case (state_q)
            ST_START: state_d = ST_DATA;
            ST_DATA: begin
              if (bitcnt_q == '0) state_d = ST_ACK;
              else                bitcnt_d = bitcnt_q - BW'(1);
            end
            ST_ACK:  state_d = stop_q ? ST_STOP : ST_DONE;
            default: state_d = ST_DONE;
          endcase
        end
      end
    endcase
  end

  // Pad outputs are registered from the next state, so the bit presented in the
  // next cycle must already reflect a load or shift happening at this edge.
  always_comb begin
    if (write_load)    tx_bit_d = TxByte[MSB];
    else if (shift_en) tx_bit_d = sr_data[MSB-1];
    else               tx_bit_d = shift_out;

    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    case (state_d)
      ST_IDLE:  sda_oe_d = 1'b0;
      ST_START: begin
        scl_d    = slot_scl(quarter_d);
        sda_oe_d = (quarter_d == Q2) || (quarter_d == Q3);
      end
      ST_DATA: begin
        scl_d    = slot_scl(quarter_d);
        sda_oe_d = !rnw_d && !tx_bit_d;
      end
      ST_ACK: begin
        scl_d    = slot_scl(quarter_d);
        sda_oe_d = rnw_d && ackout_d;
      end
      ST_STOP: begin
        scl_d    = (quarter_d != Q0);
        sda_oe_d = (quarter_d == Q0) || (quarter_d == Q1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      quarter_q <= Q0;
      qcnt_q    <= '0;
      bitcnt_q  <= '0;
      rnw_q     <= 1'b0;
      stop_q    <= 1'b0;
      ackout_q  <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      sample_q  <= 1'b0;
      ackin_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      qcnt_q    <= qcnt_d;
      bitcnt_q  <= bitcnt_d;
      rnw_q     <= rnw_d;
      stop_q    <= stop_d;
      ackout_q  <= ackout_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= state_d inside {ST_START, ST_DATA, ST_ACK, ST_STOP};
      done_q    <= (state_d == ST_DONE);
      if (state_q == ST_DATA && q2_first) sample_q <= SDA_in;
      if (accept)                                          ackin_q <= 1'b0;
      else if (state_q == ST_ACK && q2_first && !rnw_q)    ackin_q <= ~SDA_in;
    end
  end

  I2C_ShiftRegister #(
    .LENGTH(I2C_BYTE_LEN)
  ) u_shreg (
    .CLOCK       (CLOCK),
    .Reset       (Reset),
    .WriteLoad   (write_load),
    .ShiftorHold (shift_en),
    .ShiftIn     (sample_q),
    .SentData    (TxByte),
    .ShiftOut    (shift_out),
    .ReceivedData(sr_data)
  );

  assign SCL    = scl_q;
  assign SDA_oe = sda_oe_q;
  assign RxByte = sr_data;
  assign AckIn  = ackin_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule
